// File: rtl/sqrt2_arbiter.sv
// rtl/sqrt2_arbiter.sv - round-robin sharing of one fp16 sqrt2 unit over its tri-state bus
// Optional WAIT-state timeout enabled by defining SQRT2_ARB_TIMEOUT_EN.
module sqrt2_arbiter #(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [16*NREQ-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [15:0]        rsp_data,
    output logic [3:0]         rsp_flags,
    output logic               busy,
    output logic               sq_enable,
    inout  wire  [15:0]        sq_io_data,
    input  logic               sq_result,
    input  logic               sq_is_nan,
    input  logic               sq_is_pinf,
    input  logic               sq_is_ninf
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TURN,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] rr_q, rr_d;
    logic [15:0]     op_q, op_d;
    logic [15:0]     rsp_data_q, rsp_data_d;
    logic [3:0]      rsp_flags_q, rsp_flags_d;

    logic            pick_vld;
    logic [IDXW-1:0] pick_idx;
    logic [15:0]     pick_op;
    logic [IDXW:0]   rr_sum;
    logic            sq_drive;
    logic            timeout;

`ifdef SQRT2_ARB_TIMEOUT_EN
    logic [7:0] wcnt_q, wcnt_d;

    assign timeout = (wcnt_q == 8'(TIMEOUT_CYC - 1));

    always_comb begin
        wcnt_d = (state_q == S_WAIT) ? wcnt_q + 8'd1 : 8'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q <= 8'd0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Scan downward so the candidate closest to the RR pointer wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        rr_sum   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            rr_sum = {1'b0, rr_q} + (IDXW+1)'(k);
            if (rr_sum >= (IDXW+1)'(NREQ)) begin
                rr_sum = rr_sum - (IDXW+1)'(NREQ);
            end
            if (req[rr_sum[IDXW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = rr_sum[IDXW-1:0];
            end
        end
    end

    always_comb begin
        pick_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IDXW'(i)) begin
                pick_op = req_data[16*i +: 16];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            rr_q        <= '0;
            op_q        <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rr_q        <= rr_d;
            op_q        <= op_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rr_d        = rr_q;
        op_d        = op_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    state_d = S_LOAD;
                    idx_d   = pick_idx;
                    op_d    = pick_op;
                end
            end
            S_LOAD: state_d = S_TURN;
            // SQ_RESULT is not looked at here: the bus is still turning around.
            S_TURN: state_d = S_WAIT;
            S_WAIT: begin
                if (sq_result) begin
                    state_d     = S_RESP;
                    rsp_data_d  = sq_io_data;
                    rsp_flags_d = {1'b0, sq_is_ninf, sq_is_pinf, sq_is_nan};
                end else if (timeout) begin
                    state_d     = S_RESP;
                    rsp_data_d  = 16'h7e00;
                    rsp_flags_d = 4'b1001;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                rr_d    = (idx_q == IDXW'(NREQ - 1)) ? '0 : idx_q + IDXW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        gnt       = '0;
        rsp_valid = '0;
        if (rst_n && state_q == S_IDLE && pick_vld) begin
            gnt[pick_idx] = 1'b1;
        end
        if (state_q == S_RESP) begin
            rsp_valid[idx_q] = 1'b1;
        end
        sq_enable = (state_q == S_LOAD) || (state_q == S_TURN) || (state_q == S_WAIT);
        sq_drive  = (state_q == S_LOAD);
    end

    assign busy       = (state_q != S_IDLE);
    assign rsp_data   = rsp_data_q;
    assign rsp_flags  = rsp_flags_q;
    assign sq_io_data = sq_drive ? op_q : 16'hzzzz;

endmodule

// File: tb/tb_sqrt2_arbiter.sv
// tb/tb_sqrt2_arbiter.sv - randomized self-checking bench for sqrt2_arbiter with a behavioural sqrt2 stub
module tb_sqrt2_arbiter;
    localparam int NREQ        = 4;
    localparam int TIMEOUT_CYC = 64;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    req = '0;
    logic [16*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]    gnt, rsp_valid;
    logic [15:0]        rsp_data;
    logic [3:0]         rsp_flags;
    logic               busy, sq_enable;
    wire  [15:0]        sq_io_data;
    logic               sq_result = 1'b0;
    logic               sq_is_nan = 1'b0, sq_is_pinf = 1'b0, sq_is_ninf = 1'b0;
    logic               stub_drv_en = 1'b0;
    logic [15:0]        stub_drv_val = '0;

    assign sq_io_data = stub_drv_en ? stub_drv_val : 16'hzzzz;

    always #5 clk = ~clk;

    sqrt2_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_flags  (rsp_flags),
        .busy       (busy),
        .sq_enable  (sq_enable),
        .sq_io_data (sq_io_data),
        .sq_result  (sq_result),
        .sq_is_nan  (sq_is_nan),
        .sq_is_pinf (sq_is_pinf),
        .sq_is_ninf (sq_is_ninf)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // {ninf, pinf, nan, result} of an fp16 square root for the operands used here.
    function automatic logic [18:0] sqrt_ref(input logic [15:0] x);
        case (x)
            16'h0000: return {3'b000, 16'h0000};
            16'h3400: return {3'b000, 16'h3800};
            16'h3c00: return {3'b000, 16'h3c00};
            16'h4400: return {3'b000, 16'h4000};
            16'h4c00: return {3'b000, 16'h4400};
            16'h5400: return {3'b000, 16'h4800};
            16'h7c00: return {3'b010, 16'h7c00};
            default:  return {3'b001, 16'h7e00};
        endcase
    endfunction

    logic [15:0] op_tab [9] = '{16'h0000, 16'h3400, 16'h3c00, 16'h4400, 16'h4c00,
                                16'h5400, 16'h7c00, 16'hbc00, 16'hfc00};

    // sqrt2 stub: captures the operand on the ENABLE rising edge, answers stub_lat cycles later,
    // and may pulse a bogus RESULT during the turnaround cycle.
    int          force_lat  = 0;
    bit          never_resp = 1'b0;
    bit          glitch_en  = 1'b1;
    int          op_lat     = 0;
    int          stub_cnt   = 0;
    int          stub_lat   = 0;
    bit          stub_act   = 1'b0;
    bit          stub_glitch = 1'b0;
    bit          prev_en    = 1'b0;
    logic [15:0] stub_op    = '0;

    always begin
        @(posedge clk);
        #1;
        stub_drv_en = 1'b0;
        sq_result   = 1'b0;
        sq_is_nan   = 1'b0;
        sq_is_pinf  = 1'b0;
        sq_is_ninf  = 1'b0;
        if (!rst_n) begin
            stub_act = 1'b0;
            prev_en  = 1'b0;
        end else begin
            if (sq_enable && !prev_en) begin
                stub_op     = sq_io_data;
                stub_act    = 1'b1;
                stub_cnt    = 0;
                stub_lat    = (force_lat != 0) ? force_lat : int'($urandom_range(6, 2));
                stub_glitch = glitch_en && ($urandom_range(1, 0) == 1);
                op_lat      = never_resp ? TIMEOUT_CYC + 1 : stub_lat;
            end else if (stub_act) begin
                stub_cnt++;
                if (stub_cnt == 1 && stub_glitch) begin
                    sq_result    = 1'b1;
                    stub_drv_en  = 1'b1;
                    stub_drv_val = 16'h5a5a;
                    sq_is_ninf   = 1'b1;
                end
                if (stub_cnt == stub_lat && !never_resp) begin
                    {sq_is_ninf, sq_is_pinf, sq_is_nan, stub_drv_val} = sqrt_ref(stub_op);
                    sq_result   = 1'b1;
                    stub_drv_en = 1'b1;
                    stub_act    = 1'b0;
                end
            end
            prev_en = sq_enable;
        end
    end

    // Reference model: one op in flight, round-robin from the last served index + 1,
    // response exactly op_lat + 2 cycles after the grant cycle.
    int          cyc = 0;
    int          gnt_cyc = 0;
    int          cur = 0;
    int          rr_m = 0;
    bit          in_flight = 1'b0;
    bit          cur_never = 1'b0;
    logic [15:0] cur_op = '0;
    logic [15:0] exp_data = '0;
    logic [3:0]  exp_flags = '0;
    int          gnt_count [NREQ];

    initial begin
        for (int i = 0; i < NREQ; i++) gnt_count[i] = 0;
    end

    always @(negedge clk) begin : mon
        logic [NREQ-1:0] exp_gnt;
        logic [NREQ-1:0] exp_rsp;
        logic [18:0]     r;
        bit              rsp_now;
        bit              exp_en;
        int              j;
        cyc++;
        if (!rst_n) begin
            chk("rst_gnt", gnt, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_enable", sq_enable, 0);
            in_flight = 1'b0;
            rr_m      = 0;
            exp_data  = '0;
            exp_flags = '0;
        end else begin
            exp_gnt = '0;
            if (!in_flight) begin
                for (int k = 0; k < NREQ; k++) begin
                    j = (rr_m + k) % NREQ;
                    if (req[j] && exp_gnt == '0) exp_gnt[j] = 1'b1;
                end
            end
            rsp_now = in_flight && (cyc == gnt_cyc + op_lat + 2);
            exp_rsp = '0;
            if (rsp_now) begin
                exp_rsp[cur] = 1'b1;
                if (cur_never) begin
                    exp_data  = 16'h7e00;
                    exp_flags = 4'b1001;
                end else begin
                    r         = sqrt_ref(cur_op);
                    exp_data  = r[15:0];
                    exp_flags = {1'b0, r[18:16]};
                end
            end
            exp_en = in_flight && (cyc > gnt_cyc) && !rsp_now;
            chk("gnt", gnt, exp_gnt);
            chk("rsp_valid", rsp_valid, exp_rsp);
            chk("rsp_data", rsp_data, exp_data);
            chk("rsp_flags", rsp_flags, exp_flags);
            chk("busy", busy, in_flight);
            chk("sq_enable", sq_enable, exp_en);
            if (in_flight && cyc == gnt_cyc + 1) chk("bus_operand", sq_io_data, cur_op);
            if (rsp_now) begin
                in_flight = 1'b0;
                rr_m      = (cur + 1) % NREQ;
            end
            if (exp_gnt != '0) begin
                for (int k = 0; k < NREQ; k++) if (exp_gnt[k]) cur = k;
                in_flight = 1'b1;
                gnt_cyc   = cyc;
                cur_op    = req_data[16*cur +: 16];
                cur_never = never_resp;
                gnt_count[cur]++;
            end
        end
    end

    task automatic set_op(input int i, input logic [15:0] d);
        req_data[16*i +: 16] = d;
        req[i] = 1'b1;
    endtask

    task automatic wait_gnt(input logic [NREQ-1:0] exp, input bit drop, input string name);
        logic [NREQ-1:0] g;
        g = '0;
        for (int n = 0; n < 300 && g == '0; n++) begin
            @(negedge clk);
            g = gnt;
        end
        chk(name, g, exp);
        @(posedge clk);
        #2;
        if (drop) req = req & ~g;
    endtask

    task automatic wait_rsp(input logic [NREQ-1:0] ev, input logic [15:0] ed, input logic [3:0] ef,
                            input string name);
        logic [NREQ-1:0] v;
        v = '0;
        for (int n = 0; n < 300 && v == '0; n++) begin
            @(negedge clk);
            v = rsp_valid;
        end
        chk({name, "_valid"}, v, ev);
        chk({name, "_data"}, rsp_data, ed);
        chk({name, "_flags"}, rsp_flags, ef);
    endtask

    int served [NREQ];

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_enable", sq_enable, 0);
        chk("reset_rsp_data", rsp_data, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < NREQ; i++) set_op(i, 16'h3c00);
        wait_gnt(4'b0001, 1'b0, "rr_gnt0");
        wait_gnt(4'b0010, 1'b0, "rr_gnt1");
        wait_gnt(4'b0100, 1'b0, "rr_gnt2");
        wait_gnt(4'b1000, 1'b0, "rr_gnt3");
        wait_gnt(4'b0001, 1'b1, "rr_gnt0_again");
        req = '0;
        wait_rsp(4'b0001, 16'h3c00, 4'b0000, "rr_rsp");

        set_op(0, 16'h4400);
        wait_gnt(4'b0001, 1'b1, "single_gnt");
        wait_rsp(4'b0001, 16'h4000, 4'b0000, "sqrt4");

        set_op(2, 16'hbc00);
        wait_gnt(4'b0100, 1'b1, "neg_gnt");
        wait_rsp(4'b0100, 16'h7e00, 4'b0001, "neg_nan");
        set_op(2, 16'h7c00);
        wait_gnt(4'b0100, 1'b1, "inf_gnt");
        wait_rsp(4'b0100, 16'h7c00, 4'b0010, "pinf");

        set_op(0, 16'h3c00);
        set_op(3, 16'h3c00);
        wait_gnt(4'b1000, 1'b1, "wrap_first");
        wait_gnt(4'b0001, 1'b1, "wrap_second");
        wait_rsp(4'b0001, 16'h3c00, 4'b0000, "wrap");

        force_lat = 20;
        set_op(2, 16'h4400);
        wait_gnt(4'b0100, 1'b1, "abort_gnt");
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_enable", sq_enable, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rsp_data", rsp_data, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        force_lat = 0;
        for (int i = 0; i < NREQ; i++) set_op(i, 16'h4c00);
        wait_gnt(4'b0001, 1'b1, "post_reset_ptr");
        req = '0;
        wait_rsp(4'b0001, 16'h4400, 4'b0000, "post_reset");

`ifdef SQRT2_ARB_TIMEOUT_EN
        never_resp = 1'b1;
        set_op(1, 16'h3c00);
        wait_gnt(4'b0010, 1'b1, "to_gnt");
        wait_rsp(4'b0010, 16'h7e00, 4'b1001, "timeout");
        never_resp = 1'b0;
`endif

        for (int i = 0; i < NREQ; i++) served[i] = gnt_count[i];
        repeat (3000) begin
            @(posedge clk);
            #2;
            for (int i = 0; i < NREQ; i++) begin
                if (served[i] != gnt_count[i]) begin
                    req[i]    = 1'b0;
                    served[i] = gnt_count[i];
                end else if (!req[i] && $urandom_range(3, 0) == 0) begin
                    req_data[16*i +: 16] = op_tab[$urandom_range(8, 0)];
                    req[i] = 1'b1;
                end else if (req[i] && $urandom_range(63, 0) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
        req = '0;
        repeat (30) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
